// File: rtl/sonic_address_generator.sv
// sonic_address_generator
// Producer of linear DMA buffer addresses for the sonic address converter.
// A start command loads a base address and a word count. The block then
// offers one address per accepted valid/ready handshake. Each address is
// STRIDE above the previous one, wrapping modulo 2^ADDR_WIDTH. A one-cycle
// done pulse marks the normal end of a run.
module sonic_address_generator #(
    parameter int ADDR_WIDTH = 13,
    parameter int CNT_WIDTH  = 14,
    parameter int STRIDE     = 1
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic [ADDR_WIDTH-1:0] base_in,
    input  logic [CNT_WIDTH-1:0]  count_in,
    input  logic                  abort_in,
    output logic [ADDR_WIDTH-1:0] address_out,
    output logic                  addr_valid_out,
    input  logic                  addr_ready_in,
    output logic                  busy_out,
    output logic                  done_out,
    output logic [CNT_WIDTH-1:0]  words_left_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(STRIDE);
    localparam logic [CNT_WIDTH-1:0]  CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [ADDR_WIDTH-1:0]   addr_next;
    logic [CNT_WIDTH-1:0]    left;
    logic [CNT_WIDTH-1:0]    left_next;
    logic                    accept;

    // Address step. Unsigned overflow of the ADDR_WIDTH-bit sum is the
    // intended modulo-2^ADDR_WIDTH wrap, so no flag and no stall are needed.
    function automatic logic [ADDR_WIDTH-1:0] wrap_add(input logic [ADDR_WIDTH-1:0] a);
        return a + STEP;
    endfunction

    // A word is consumed only while an address is actually on offer.
    assign accept = (state == RUN) && addr_ready_in;

    // State, address and remaining-count registers; reset wins over everything
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
            addr  <= '0;
            left  <= '0;
        end else begin
            state <= state_next;
            addr  <= addr_next;
            left  <= left_next;
        end
    end

    // Next-state and next-datapath decode
    always_comb begin
        state_next = state;
        addr_next  = addr;
        left_next  = left;
        case (state)
            IDLE: begin
                if (start_in) begin
                    if (count_in != CNT_ZERO) begin
                        addr_next  = base_in;
                        left_next  = count_in;
                        state_next = RUN;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            RUN: begin
                // An abort beats a simultaneous acceptance. The word still
                // counts as taken by the consumer, but nothing further is
                // issued and no completion is reported.
                if (abort_in) begin
                    left_next  = CNT_ZERO;
                    state_next = IDLE;
                end else if (accept) begin
                    if (left == CNT_ONE) begin
                        left_next  = CNT_ZERO;
                        state_next = DONE;
                    end else begin
                        addr_next = wrap_add(addr);
                        left_next = left - CNT_ONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Handshake and status outputs come straight from registered state,
    // so they are glitch-free and all read zero right after reset.
    assign address_out    = addr;
    assign words_left_out = left;
    assign addr_valid_out = (state == RUN);
    assign busy_out       = (state == RUN);
    assign done_out       = (state == DONE);

endmodule

// File: tb/tb_sonic_address_generator.sv
// Testbench for sonic_address_generator.
// Directed stimulus with literal expectations, plus a queue-based reference
// model whose outputs are compared against the DUT on every cycle.
module tb_sonic_address_generator;

    localparam int AW = 13;
    localparam int CW = 14;
    localparam int ST = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base;
    logic [CW-1:0] count;
    logic          abort;
    logic [AW-1:0] address;
    logic          addr_valid;
    logic          addr_ready;
    logic          busy;
    logic          done;
    logic [CW-1:0] words_left;

    int n_checks = 0;
    int n_fail   = 0;

    sonic_address_generator #(
        .ADDR_WIDTH(AW),
        .CNT_WIDTH (CW),
        .STRIDE    (ST)
    ) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .start_in      (start),
        .base_in       (base),
        .count_in      (count),
        .abort_in      (abort),
        .address_out   (address),
        .addr_valid_out(addr_valid),
        .addr_ready_in (addr_ready),
        .busy_out      (busy),
        .done_out      (done),
        .words_left_out(words_left)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model. The run is a queue of the addresses still to be
    // handed over; its front is what must be on the bus and its length is
    // the remaining count.
    int            m_q[$];
    bit            m_done    = 1'b0;
    int            m_hold    = 0;
    bit            m_started = 1'b0;

    always @(posedge clk) begin
        bit nd;
        m_started = 1'b1;
        nd = 1'b0;
        if (rst) begin
            m_q.delete();
            m_hold = 0;
        end else if (m_done) begin
            nd = 1'b0;
        end else if (m_q.size() == 0) begin
            if (start) begin
                if (count != 0) begin
                    for (int i = 0; i < int'(count); i++)
                        m_q.push_back((int'(base) + i * ST) % (1 << AW));
                end else begin
                    nd = 1'b1;
                end
            end
        end else begin
            if (abort) begin
                m_q.delete();
            end else if (addr_ready) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) nd = 1'b1;
            end
        end
        m_done = nd;
        if (m_q.size() > 0) m_hold = m_q[0];
    end

    // Per-cycle comparison against the model, just after each edge.
    always @(posedge clk) begin
        #1;
        if (m_started) begin
            chk("cyc_valid", {31'd0, addr_valid}, {31'd0, m_q.size() > 0});
            chk("cyc_busy", {31'd0, busy}, {31'd0, m_q.size() > 0});
            chk("cyc_done", {31'd0, done}, {31'd0, m_done});
            chk("cyc_left", 32'(words_left), 32'(m_q.size()));
            chk("cyc_addr", 32'(address), (m_q.size() > 0) ? m_q[0] : m_hold);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic start_run(input logic [AW-1:0] b, input logic [CW-1:0] c);
        start = 1'b1;
        base  = b;
        count = c;
        step();
        start = 1'b0;
    endtask

    task automatic basic_run(input string tag);
        addr_ready = 1'b1;
        start_run(13'h0010, 14'd4);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_addr"}, 32'(address), 32'h10 + i);
            chk({tag, "_left"}, 32'(words_left), 32'(4 - i));
            chk({tag, "_valid"}, {31'd0, addr_valid}, 32'd1);
            step();
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_valid_end"}, {31'd0, addr_valid}, 32'd0);
        chk({tag, "_addr_hold"}, 32'(address), 32'h13);
        step();
        chk({tag, "_done_off"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        base       = '0;
        count      = '0;
        abort      = 1'b0;
        addr_ready = 1'b0;
        step();
        step();
        chk("rst_addr", 32'(address), 32'd0);
        chk("rst_valid", {31'd0, addr_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_left", 32'(words_left), 32'd0);
        rst = 1'b0;

        // Abort while idle must do nothing.
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("idle_abort_busy", {31'd0, busy}, 32'd0);

        // Basic run with the consumer always ready.
        basic_run("basic");

        // Backpressure on the second word.
        start_run(13'h0100, 14'd3);
        chk("bp_addr0", 32'(address), 32'h100);
        step();
        chk("bp_addr1", 32'(address), 32'h101);
        addr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold_addr", 32'(address), 32'h101);
            chk("bp_hold_valid", {31'd0, addr_valid}, 32'd1);
            chk("bp_hold_left", 32'(words_left), 32'd2);
            step();
        end
        addr_ready = 1'b1;
        chk("bp_addr1_again", 32'(address), 32'h101);
        step();
        chk("bp_addr2", 32'(address), 32'h102);
        step();
        chk("bp_done", {31'd0, done}, 32'd1);
        step();

        // Wrap-around at the top of the address space.
        start_run(13'h1FFE, 14'd4);
        chk("wrap_a0", 32'(address), 32'h1FFE);
        step();
        chk("wrap_a1", 32'(address), 32'h1FFF);
        step();
        chk("wrap_a2", 32'(address), 32'h0000);
        step();
        chk("wrap_a3", 32'(address), 32'h0001);
        step();
        chk("wrap_done", {31'd0, done}, 32'd1);
        step();

        // Zero count: straight to DONE, no valid. Start during DONE ignored.
        start_run(13'h0055, 14'd0);
        chk("zero_valid", {31'd0, addr_valid}, 32'd0);
        chk("zero_done", {31'd0, done}, 32'd1);
        start = 1'b1;
        count = 14'd3;
        step();
        start = 1'b0;
        chk("zero_done_off", {31'd0, done}, 32'd0);
        chk("done_start_ignored", {31'd0, addr_valid}, 32'd0);
        step();

        // Abort together with an acceptance and a start request.
        start_run(13'h0000, 14'd10);
        step();
        step();
        step();
        chk("abort_pre_addr", 32'(address), 32'h3);
        abort = 1'b1;
        start = 1'b1;
        base  = 13'h0077;
        count = 14'd5;
        step();
        abort = 1'b0;
        start = 1'b0;
        chk("abort_valid", {31'd0, addr_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_left", 32'(words_left), 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        step();
        chk("abort_no_done", {31'd0, done}, 32'd0);
        chk("abort_start_ignored", {31'd0, addr_valid}, 32'd0);
        start_run(13'h0020, 14'd1);
        chk("single_addr", 32'(address), 32'h20);
        chk("single_left", 32'(words_left), 32'd1);
        step();
        chk("single_done", {31'd0, done}, 32'd1);
        chk("single_addr_hold", 32'(address), 32'h20);
        step();

        // Reset in the middle of a run.
        start_run(13'h0040, 14'd8);
        step();
        step();
        chk("mid_pre_addr", 32'(address), 32'h42);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_addr", 32'(address), 32'd0);
        chk("mid_rst_valid", {31'd0, addr_valid}, 32'd0);
        chk("mid_rst_left", 32'(words_left), 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        step();
        chk("mid_rst_no_done", {31'd0, done}, 32'd0);
        basic_run("rerun");

        // Full-size run covers every address exactly once.
        start_run(13'h0005, 14'd8192);
        chk("full_left", 32'(words_left), 32'd8192);
        for (int i = 0; i < 8192; i++) step();
        chk("full_done", {31'd0, done}, 32'd1);
        chk("full_last_addr", 32'(address), 32'h0004);
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
